// File: rtl/bw_pool_28x28.sv
// Black/white frame downsampler: counts white pixels per 8x8 block of a centred
// 224x224 window and streams the 28x28 counts over a valid/ready port.
module bw_pool_28x28 #(
    parameter int unsigned IMG_W   = 320,
    parameter int unsigned IMG_H   = 240,
    parameter int unsigned WIN_X0  = 48,
    parameter int unsigned WIN_Y0  = 8,
    parameter int unsigned BLK     = 8,
    parameter int unsigned OUT_DIM = 28
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iSTART,
    input  logic        iDVAL,
    input  logic        iPIX,
    input  logic [15:0] iX_Cont,
    input  logic [15:0] iY_Cont,
    output logic [15:0] oDATA,
    output logic        oVALID,
    input  logic        iREADY,
    output logic        oLAST,
    output logic        oBUSY,
    output logic        oDONE,
    output logic        oERR
);

    localparam int unsigned WIN    = BLK * OUT_DIM;
    localparam int unsigned NWORDS = OUT_DIM * OUT_DIM;
    localparam int unsigned BLK_SH = $clog2(BLK);
    localparam int unsigned CW     = $clog2(OUT_DIM);
    localparam int unsigned AW     = $clog2(NWORDS);
    localparam int unsigned CNT_W  = $clog2(BLK * BLK + 1);

    localparam logic [15:0] X_LO   = 16'(WIN_X0);
    localparam logic [15:0] X_HI   = 16'(WIN_X0 + WIN);
    localparam logic [15:0] X_LAST = 16'(WIN_X0 + WIN - 1);
    localparam logic [15:0] Y_LO   = 16'(WIN_Y0);
    localparam logic [15:0] Y_HI   = 16'(WIN_Y0 + WIN);
    localparam logic [15:0] X_MAX  = 16'(IMG_W);
    localparam logic [15:0] Y_MAX  = 16'(IMG_H);
    localparam logic [CW-1:0] LAST_COL  = CW'(OUT_DIM - 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(NWORDS - 1);

    typedef enum logic [1:0] {StIdle, StArmed, StCapture, StDrain} state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0] acc_q [OUT_DIM];
    logic [CNT_W-1:0] frame_mem [NWORDS];

    logic          commit_act_q;
    logic [CW-1:0] commit_col_q, commit_row_q;
    logic [AW-1:0] wr_addr;

    logic [AW-1:0]    rd_idx_q;
    logic             rd_end_q;
    logic [CNT_W-1:0] rd_data_q;
    logic             out_valid_q, out_last_q;
    logic             done_q, err_q;

    logic [15:0]   dx, dy;
    logic [CW-1:0] pix_col, blk_row;
    logic          sof, in_win, row_end, capturing, frame_err, pix_inc, commit_start;
    logic          commit_last, capture_done, fire, drain_done, start_idle, advance;

    assign sof        = iDVAL && (iX_Cont == 16'd0) && (iY_Cont == 16'd0);
    assign dx         = iX_Cont - X_LO;
    assign dy         = iY_Cont - Y_LO;
    assign in_win     = (iX_Cont >= X_LO) && (iX_Cont < X_HI) && (iX_Cont < X_MAX) &&
                        (iY_Cont >= Y_LO) && (iY_Cont < Y_HI) && (iY_Cont < Y_MAX);
    assign pix_col    = CW'(dx >> BLK_SH);
    assign blk_row    = CW'(dy >> BLK_SH);
    assign row_end    = (dy[BLK_SH-1:0] == {BLK_SH{1'b1}});
    assign start_idle = (state_q == StIdle) && iSTART;

    // A second start-of-frame while capturing means the frame sync was lost.
    assign capturing    = (state_q == StCapture);
    assign frame_err    = capturing && sof;
    assign pix_inc      = capturing && !sof && iDVAL && in_win && iPIX;
    assign commit_start = capturing && !sof && iDVAL && in_win && (iX_Cont == X_LAST) && row_end;
    assign commit_last  = commit_act_q && (commit_col_q == LAST_COL);
    assign capture_done = commit_last && (commit_row_q == LAST_COL);
    assign wr_addr      = AW'(commit_row_q * OUT_DIM + commit_col_q);

    assign fire       = out_valid_q && iREADY;
    assign drain_done = (state_q == StDrain) && fire && out_last_q;
    assign advance    = !out_valid_q || iREADY;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (iSTART) state_d = StArmed;
            StArmed:   if (sof) state_d = StCapture;
            StCapture: begin
                if (frame_err) state_d = StIdle;
                else if (capture_done) state_d = StDrain;
            end
            StDrain:   if (drain_done) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) state_q <= StIdle;
        else         state_q <= state_d;
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int unsigned i = 0; i < OUT_DIM; i++) acc_q[i] <= '0;
        end else if (frame_err || start_idle) begin
            for (int unsigned i = 0; i < OUT_DIM; i++) acc_q[i] <= '0;
        end else begin
            if (commit_act_q) acc_q[commit_col_q] <= '0;
            if (pix_inc) acc_q[pix_col] <= acc_q[pix_col] + CNT_W'(1);
        end
    end

    // Commit walks the accumulators in the blanking gap after the last window column.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            commit_act_q <= 1'b0;
            commit_col_q <= '0;
            commit_row_q <= '0;
        end else if (frame_err) begin
            commit_act_q <= 1'b0;
        end else if (commit_start) begin
            commit_act_q <= 1'b1;
            commit_col_q <= '0;
            commit_row_q <= blk_row;
        end else if (commit_act_q) begin
            if (commit_last) commit_act_q <= 1'b0;
            commit_col_q <= commit_col_q + CW'(1);
        end
    end

    always_ff @(posedge iCLK) begin
        if (commit_act_q) frame_mem[wr_addr] <= acc_q[commit_col_q];
    end

    // Output word is the registered memory read; it only advances when the slot is free.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            rd_idx_q    <= '0;
            rd_end_q    <= 1'b0;
            rd_data_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (state_q != StDrain) begin
            rd_idx_q    <= '0;
            rd_end_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (advance) begin
            if (!rd_end_q) begin
                rd_data_q   <= frame_mem[rd_idx_q];
                out_valid_q <= 1'b1;
                out_last_q  <= (rd_idx_q == LAST_ADDR);
                if (rd_idx_q == LAST_ADDR) rd_end_q <= 1'b1;
                else rd_idx_q <= rd_idx_q + AW'(1);
            end else begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= drain_done;
            if (start_idle) err_q <= 1'b0;
            else if (frame_err) err_q <= 1'b1;
        end
    end

    assign oDATA  = {{(16 - CNT_W){1'b0}}, rd_data_q};
    assign oVALID = out_valid_q;
    assign oLAST  = out_last_q;
    assign oBUSY  = (state_q != StIdle);
    assign oDONE  = done_q;
    assign oERR   = err_q;

endmodule
